dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller between the execute/memory stage and main memory.
- Consumes d_mem_r/d_mem_w from the instruction decoder with the ALU address, and returns load data.
- Stalls the pipeline via busy while a miss is serviced.
- Sequences dirty-block writeback and block refill over a request/acknowledge memory handshake.

Parameters:
- ADDR_W, 32: byte address width.
- INDEX_W, 3: index bits; 2**INDEX_W lines.
- OFFSET_W, 2: word-offset bits; 2**OFFSET_W 32-bit words per block.
- TAG_W, ADDR_W-INDEX_W-OFFSET_W-2: derived, not overridable.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- d_mem_r  in  1  load request from decoder.
- d_mem_w  in  1  store request from decoder.
- address  in  ADDR_W  byte address from ALU; bits[1:0] ignored (word accesses only).
- wr_data  in  32  store data.
- rd_data  out  32  load data; valid when d_mem_r=1 and busy=0.
- busy  out  1  stall to pipeline.
- mem_read  out  1  block read request.
- mem_write  out  1  block write request.
- mem_address  out  ADDR_W-OFFSET_W-2  block address.
- mem_wr_data  out  32*2**OFFSET_W  writeback block.
- mem_rd_data  in  32*2**OFFSET_W  refill block.
- mem_ack  in  1  one-cycle completion pulse from memory.

Behaviour:
- Reset (async):
  - All valid and dirty bits cleared; state=IDLE.
  - busy=0, mem_read=0, mem_write=0, mem_address=0, mem_wr_data=0, rd_data=0.
  - Reset mid-miss abandons the transaction immediately; a late mem_ack is ignored.
- Address split: offset=address[OFFSET_W+1:2], index=next INDEX_W bits, tag=remaining upper bits.
- hit = valid[index] && tag match.
- IDLE:
  - No request: busy=0.
  - Read hit: rd_data = selected word combinationally; busy=0; zero-cycle latency.
  - Write hit: busy=0; word written at the next rising edge; dirty[index] set.
  - Miss (d_mem_r|d_mem_w and !hit): busy=1 combinationally in the same cycle. Latch address, wr_data and the request type. Next state is WRITEBACK if valid&&dirty, else ALLOCATE.
  - d_mem_r and d_mem_w both high: treated as a write (the decoder never issues both).
- WRITEBACK:
  - mem_write=1, mem_address={stored tag, index}, mem_wr_data=stored block.
  - All held stable until mem_ack; on mem_ack go to ALLOCATE and drop mem_write next cycle.
- ALLOCATE:
  - mem_read=1, mem_address={latched tag, index}; held until mem_ack.
  - On mem_ack, capture mem_rd_data and go to UPDATE.
- UPDATE (1 cycle):
  - Write the block, tag, valid=1, dirty=0.
  - A latched store merges wr_data into the word and sets dirty=1.
  - Return to IDLE; busy stays 1 this cycle.
- Back in IDLE the request re-evaluates as a hit and busy falls.
- Miss latency, clean line: 1 (detect) + memory cycles to ack + 1 (UPDATE); busy drops in the following IDLE cycle.
- Miss latency, dirty line: the writeback handshake is added.
- Inputs changing while busy=1 are ignored; the latched copy is used.
- mem_ack outside WRITEBACK/ALLOCATE is ignored.
- mem_read and mem_write are never high together.

Optional Feature:
- Macro DCACHE_STATS_EN.
- When defined: adds outputs hit_count[31:0] and miss_count[31:0].
  - Each counts one per request evaluated in IDLE: a miss counts once; the post-refill hit is not counted.
  - Counters saturate at 0xFFFFFFFF and are cleared by reset.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/include dcache_pkg holds:
  - State encoding: IDLE=0, WRITEBACK=1, ALLOCATE=2, UPDATE=3.
  - Derived width constants: TAG_W, BLOCK_W.
- One sub-module, dcache_array:
  - Tag/valid/dirty/data storage with asynchronous read and synchronous write.
  - Valid/dirty cleared by reset.
- The FSM lives in dcache_ctrl.

Test Plan:
1. After reset, load at 0x00000010 → busy=1 same cycle, then mem_read=1 with mem_address=0x0000001. Return mem_ack after 3 cycles with block {0x44,0x33,0x22,0x11} (word0=0x11) → after UPDATE, busy=0 and rd_data=0x00000011.
2. Store 0xDEADBEEF to 0x00000014 (hit, line 1) → busy stays 0. A following load at 0x00000014 returns 0xDEADBEEF with zero stall.
3. Load at 0x00000090 (same index 1, different tag, dirty line) → mem_write=1 at mem_address=0x0000001 with word1=0xDEADBEEF. After mem_ack, mem_read=1 at 0x0000009. Never both requests high.
4. Store miss to 0x00000020 on a clean invalid line → ALLOCATE, then UPDATE merges the word. Later eviction writes back the merged value.
5. Assert reset during ALLOCATE, then pulse mem_ack → mem_read drops immediately, busy=0, the ack is ignored, and the next load at 0x00000010 misses.
6. With DCACHE_STATS_EN, run scenarios 1–3 → hit_count=2, miss_count=2.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared definitions for the direct-mapped write-back data cache.
//   state_t         controller state encoding (IDLE/WRITEBACK/ALLOCATE/UPDATE)
//   calc_tag_w()    tag width from address/index/offset widths
//   calc_block_w()  block width in bits from the word-offset width
//   TAG_W, BLOCK_W  derived widths for the default geometry (32/3/2)
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  localparam int unsigned WORD_W = 32;

  function automatic int unsigned calc_tag_w(input int unsigned addr_w,
                                             input int unsigned index_w,
                                             input int unsigned offset_w);
    return addr_w - index_w - offset_w - 2;
  endfunction

  function automatic int unsigned calc_block_w(input int unsigned offset_w);
    return WORD_W << offset_w;
  endfunction

  localparam int unsigned TAG_W   = calc_tag_w(32, 3, 2);
  localparam int unsigned BLOCK_W = calc_block_w(2);

endpackage

// File: rtl/dcache_array.sv
// dcache_array: tag/valid/dirty/data storage for the direct-mapped cache.
// Ports:
//   clk, reset        clock and asynchronous active-high reset (clears valid/dirty)
//   rd_index          line selected for the asynchronous read
//   rd_valid/rd_dirty/rd_tag/rd_block   contents of the selected line
//   we, wr_index      synchronous write enable and target line
//   wr_tag/wr_block/wr_dirty            new line contents; valid is set on write
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_W    = 3,
  parameter int unsigned TAG_BITS   = TAG_W,
  parameter int unsigned BLOCK_BITS = BLOCK_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_W-1:0]    rd_index,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [BLOCK_BITS-1:0] rd_block,
  input  logic                  we,
  input  logic [INDEX_W-1:0]    wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [BLOCK_BITS-1:0] wr_block,
  input  logic                  wr_dirty
);

  localparam int unsigned LINES = 1 << INDEX_W;

  logic [LINES-1:0]      valid;
  logic [LINES-1:0]      dirty;
  logic [TAG_BITS-1:0]   tags   [LINES];
  logic [BLOCK_BITS-1:0] blocks [LINES];

  assign rd_valid = valid[rd_index];
  assign rd_dirty = dirty[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_block = blocks[rd_index];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else if (we) begin
      valid[wr_index] <= 1'b1;
      dirty[wr_index] <= wr_dirty;
    end
  end

  // Tag and data contents are meaningless while valid is clear, so no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      tags[wr_index]   <= wr_tag;
      blocks[wr_index] <= wr_block;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   d_mem_r, d_mem_w      load / store request (both high acts as a store)
//   address, wr_data      byte address (bits [1:0] ignored) and store data
//   rd_data               load data, valid when d_mem_r=1 and busy=0
//   busy                  pipeline stall while a miss is being serviced
//   mem_read, mem_write   block refill / writeback requests, held until mem_ack
//   mem_address           block address {tag, index}
//   mem_wr_data           block being written back
//   mem_rd_data, mem_ack  refill block and one-cycle completion pulse
//   hit_count, miss_count saturating request counters (DCACHE_STATS_EN only)
// Optional feature macro: DCACHE_STATS_EN.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned INDEX_W  = 3,
  parameter int unsigned OFFSET_W = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                d_mem_r,
  input  logic                                d_mem_w,
  input  logic [ADDR_W-1:0]                   address,
  input  logic [31:0]                         wr_data,
  output logic [31:0]                         rd_data,
  output logic                                busy,
  output logic                                mem_read,
  output logic                                mem_write,
  output logic [ADDR_W-OFFSET_W-3:0]          mem_address,
  output logic [calc_block_w(OFFSET_W)-1:0]   mem_wr_data,
  input  logic [calc_block_w(OFFSET_W)-1:0]   mem_rd_data,
  input  logic                                mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]                         hit_count,
  output logic [31:0]                         miss_count
`endif
);

  localparam int unsigned TAG_BITS   = calc_tag_w(ADDR_W, INDEX_W, OFFSET_W);
  localparam int unsigned BLOCK_BITS = calc_block_w(OFFSET_W);
  localparam int unsigned WORDS      = 1 << OFFSET_W;

  logic [OFFSET_W-1:0] offset_in;
  logic [INDEX_W-1:0]  index_in;
  logic [TAG_BITS-1:0] tag_in;
  logic                unused_low;

  assign offset_in  = address[OFFSET_W+1:2];
  assign index_in   = address[OFFSET_W+2 +: INDEX_W];
  assign tag_in     = address[ADDR_W-1 -: TAG_BITS];
  assign unused_low = ^address[1:0];

  logic                  line_valid;
  logic                  line_dirty;
  logic [TAG_BITS-1:0]   line_tag;
  logic [BLOCK_BITS-1:0] line_block;
  logic                  we;
  logic [INDEX_W-1:0]    w_index;
  logic [TAG_BITS-1:0]   w_tag;
  logic [BLOCK_BITS-1:0] w_block;
  logic                  w_dirty;

  dcache_array #(
    .INDEX_W   (INDEX_W),
    .TAG_BITS  (TAG_BITS),
    .BLOCK_BITS(BLOCK_BITS)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .rd_index(index_in),
    .rd_valid(line_valid),
    .rd_dirty(line_dirty),
    .rd_tag  (line_tag),
    .rd_block(line_block),
    .we      (we),
    .wr_index(w_index),
    .wr_tag  (w_tag),
    .wr_block(w_block),
    .wr_dirty(w_dirty)
  );

  state_t                state;
  logic [TAG_BITS-1:0]   lat_tag;
  logic [INDEX_W-1:0]    lat_index;
  logic [OFFSET_W-1:0]   lat_offset;
  logic [31:0]           lat_data;
  logic                  lat_write;
  logic [BLOCK_BITS-1:0] refill;

  logic        req;
  logic        hit;
  logic        miss;
  logic [31:0] rd_word;

  assign req  = d_mem_r | d_mem_w;
  assign hit  = line_valid && (line_tag == tag_in);
  assign miss = (state == IDLE) && req && !hit;
  assign busy = (state != IDLE) || miss;

  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (offset_in == OFFSET_W'(i)) rd_word = line_block[32*i +: 32];
    end
  end

  assign rd_data = (state == IDLE && d_mem_r && hit) ? rd_word : '0;

  // Single array write port: a store hit in IDLE merges into the resident
  // line; UPDATE installs the refilled block (with a pending store merged).
  always_comb begin
    we      = 1'b0;
    w_index = index_in;
    w_tag   = tag_in;
    w_dirty = 1'b1;
    w_block = line_block;
    if (state == UPDATE) begin
      we      = 1'b1;
      w_index = lat_index;
      w_tag   = lat_tag;
      w_dirty = lat_write;
      w_block = refill;
      if (lat_write) begin
        for (int unsigned i = 0; i < WORDS; i++) begin
          if (lat_offset == OFFSET_W'(i)) w_block[32*i +: 32] = lat_data;
        end
      end
    end else if (state == IDLE && d_mem_w && hit) begin
      we = 1'b1;
      for (int unsigned i = 0; i < WORDS; i++) begin
        if (offset_in == OFFSET_W'(i)) w_block[32*i +: 32] = wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wr_data <= '0;
      lat_tag     <= '0;
      lat_index   <= '0;
      lat_offset  <= '0;
      lat_data    <= '0;
      lat_write   <= 1'b0;
      refill      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            lat_tag    <= tag_in;
            lat_index  <= index_in;
            lat_offset <= offset_in;
            lat_data   <= wr_data;
            lat_write  <= d_mem_w;
            if (line_valid && line_dirty) begin
              state       <= WRITEBACK;
              mem_write   <= 1'b1;
              mem_address <= {line_tag, index_in};
              mem_wr_data <= line_block;
            end else begin
              state       <= ALLOCATE;
              mem_read    <= 1'b1;
              mem_address <= {tag_in, index_in};
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            state       <= ALLOCATE;
            mem_write   <= 1'b0;
            mem_read    <= 1'b1;
            mem_address <= {lat_tag, lat_index};
          end
        end
        ALLOCATE: begin
          if (mem_ack) begin
            state    <= UPDATE;
            mem_read <= 1'b0;
            refill   <= mem_rd_data;
          end
        end
        UPDATE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  // The first IDLE cycle after a refill re-evaluates the same request as a
  // hit; that hit belongs to the miss already counted.
  logic refilled;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
      refilled   <= 1'b0;
    end else if (state == UPDATE) begin
      refilled <= 1'b1;
    end else if (state == IDLE) begin
      refilled <= 1'b0;
      if (req && !hit && miss_count != '1) miss_count <= miss_count + 32'd1;
      if (req && hit && !refilled && hit_count != '1) hit_count <= hit_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: self-checking bench for dcache_ctrl (default 32/3/2 geometry).
// A behavioural memory answers block requests after a chosen delay; a flat
// word-level reference memory plus a per-line tag/valid/dirty table predicts
// hit/miss, stall length, writebacks and load data.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         d_mem_r;
  logic         d_mem_w;
  logic [31:0]  address;
  logic [31:0]  wr_data;
  logic [31:0]  rd_data;
  logic         busy;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_wr_data;
  logic [127:0] mem_rd_data = '0;
  logic         mem_ack;
  logic         resp_ack = 1'b0;
  logic         man_ack = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  assign mem_ack = resp_ack | man_ack;

  int unsigned errors = 0;
  int unsigned checks = 0;

  dcache_ctrl #(.ADDR_W(32), .INDEX_W(3), .OFFSET_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .d_mem_r    (d_mem_r),
    .d_mem_w    (d_mem_w),
    .address    (address),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .busy       (busy),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_address(mem_address),
    .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data),
    .mem_ack    (mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- backing memory ----------------
  logic [127:0] bmem [int unsigned];
  logic [31:0]  gold [int unsigned];

  function automatic logic [31:0] pat(input int unsigned wa);
    return wa * 32'h9E3779B1 + 32'h13579BDF;
  endfunction

  function automatic logic [31:0] mem_word(input int unsigned wa);
    logic [127:0] b;
    if (bmem.exists(wa >> 2)) begin
      b = bmem[wa >> 2];
      return b[32*(wa % 4) +: 32];
    end
    return pat(wa);
  endfunction

  function automatic logic [127:0] mem_block(input int unsigned ba);
    logic [127:0] b;
    for (int i = 0; i < 4; i++) b[32*i +: 32] = mem_word(ba * 4 + i);
    return b;
  endfunction

  function automatic logic [31:0] gval(input int unsigned wa);
    if (gold.exists(wa)) return gold[wa];
    return mem_word(wa);
  endfunction

  // ---------------- memory responder ----------------
  int unsigned cnt = 0;
  int unsigned wdelay = 3;
  int unsigned rdelay = 3;
  bit          resp_en = 1'b1;
  int unsigned wb_cnt = 0;
  int unsigned rd_cnt = 0;
  logic [27:0] wb_addr = '0;
  logic [27:0] rd_addr = '0;
  logic [127:0] wb_blk = '0;

  always @(negedge clk) begin
    if (resp_ack) begin
      resp_ack = 1'b0;
      cnt = 0;
    end
    if (mem_read || mem_write) begin
      chk("never_both_req", {127'd0, mem_read && mem_write}, 128'd0);
      if (resp_en) begin
        cnt++;
        if (cnt == (mem_write ? wdelay : rdelay)) begin
          resp_ack = 1'b1;
          if (mem_write) begin
            bmem[mem_address] = mem_wr_data;
            wb_cnt++;
            wb_addr = mem_address;
            wb_blk = mem_wr_data;
          end else begin
            mem_rd_data = mem_block(mem_address);
            rd_cnt++;
            rd_addr = mem_address;
          end
        end
      end
    end else begin
      cnt = 0;
    end
  end

  // ---------------- reference cache model ----------------
  bit          m_valid [8];
  bit          m_dirty [8];
  int unsigned m_tag   [8];
  int unsigned m_hits = 0;
  int unsigned m_misses = 0;

  task automatic model_predict(input bit w, input logic [31:0] a, input logic [31:0] d,
                               output bit e_miss, output int unsigned e_cyc, output bit e_wb,
                               output logic [27:0] e_wba, output logic [127:0] e_wbb,
                               output logic [31:0] e_rd);
    int unsigned idx;
    int unsigned tg;
    int unsigned ba;
    idx = (a >> 4) % 8;
    tg = a >> 7;
    e_miss = !(m_valid[idx] && m_tag[idx] == tg);
    e_wb = e_miss && m_valid[idx] && m_dirty[idx];
    e_wba = '0;
    e_wbb = '0;
    if (e_wb) begin
      ba = m_tag[idx] * 8 + idx;
      e_wba = ba[27:0];
      for (int i = 0; i < 4; i++) e_wbb[32*i +: 32] = gval(ba * 4 + i);
    end
    e_cyc = e_miss ? 2 + rdelay + (e_wb ? wdelay : 0) : 0;
    if (e_miss) begin
      m_valid[idx] = 1'b1;
      m_tag[idx] = tg;
      m_dirty[idx] = 1'b0;
      m_misses++;
    end else begin
      m_hits++;
    end
    if (w) begin
      m_dirty[idx] = 1'b1;
      gold[a >> 2] = d;
    end
    e_rd = gval(a >> 2);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    reset = 1'b1;
    d_mem_r = 1'b0;
    d_mem_w = 1'b0;
    address = '0;
    wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_wr_data", mem_wr_data, 0);
    chk("rst_rd_data", rd_data, 0);
`ifdef DCACHE_STATS_EN
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);
`endif
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i] = 0;
    end
    gold.delete();
    m_hits = 0;
    m_misses = 0;
  endtask

  // Called just after a rising edge; holds the request until busy falls,
  // keeps it for the completing cycle, then drops it.
  task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d,
                        output bit b0, output int unsigned cyc, output logic [31:0] rdv);
    wb_cnt = 0;
    rd_cnt = 0;
    d_mem_r = !w;
    d_mem_w = w;
    address = a;
    wr_data = d;
    #1;
    b0 = busy;
    cyc = 0;
    while (busy && cyc < 64) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("busy_release", busy, 0);
    rdv = rd_data;
    @(posedge clk);
    #1;
    d_mem_r = 1'b0;
    d_mem_w = 1'b0;
  endtask

  typedef struct {
    bit           w;
    logic [31:0]  a;
    logic [31:0]  d;
    bit           busy0;
    int unsigned  cyc;
    logic [31:0]  rd;
    bit           wb;
    logic [27:0]  wba;
    logic [127:0] wbb;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit           b0;
    int unsigned  cyc;
    logic [31:0]  rdv;
    bit           e_miss;
    bit           e_wb;
    int unsigned  e_cyc;
    logic [27:0]  e_wba;
    logic [127:0] e_wbb;
    logic [31:0]  e_rd;
    bit           w;
    logic [31:0]  a;
    logic [31:0]  d;
    int unsigned  k;

    vecs[0] = '{1'b0, 32'h10, 32'h0,        1'b1, 5, 32'h11,       1'b0, 28'h0, 128'h0};
    vecs[1] = '{1'b1, 32'h14, 32'hDEADBEEF, 1'b0, 0, 32'h0,        1'b0, 28'h0, 128'h0};
    vecs[2] = '{1'b0, 32'h14, 32'h0,        1'b0, 0, 32'hDEADBEEF, 1'b0, 28'h0, 128'h0};
    vecs[3] = '{1'b0, 32'h90, 32'h0,        1'b1, 8, pat(32'h24),  1'b1, 28'h1,
                {32'h44, 32'h33, 32'hDEADBEEF, 32'h11}};
    vecs[4] = '{1'b1, 32'h20, 32'hCAFEF00D, 1'b1, 5, 32'h0,        1'b0, 28'h0, 128'h0};
    vecs[5] = '{1'b0, 32'h20, 32'h0,        1'b0, 0, 32'hCAFEF00D, 1'b0, 28'h0, 128'h0};
    vecs[6] = '{1'b0, 32'hA0, 32'h0,        1'b1, 8, pat(32'h28),  1'b1, 28'h2,
                {pat(11), pat(10), pat(9), 32'hCAFEF00D}};

    bmem[1] = {32'h44, 32'h33, 32'h22, 32'h11};
    do_reset();

    // Directed table: refill, store hit, dirty eviction, store-miss merge.
    wdelay = 3;
    rdelay = 3;
    for (int i = 0; i < 7; i++) begin
      access(vecs[i].w, vecs[i].a, vecs[i].d, b0, cyc, rdv);
      chk($sformatf("v%0d_busy0", i), b0, vecs[i].busy0);
      chk($sformatf("v%0d_cycles", i), cyc, vecs[i].cyc);
      if (!vecs[i].w) chk($sformatf("v%0d_rd_data", i), rdv, vecs[i].rd);
      chk($sformatf("v%0d_wb_count", i), wb_cnt, vecs[i].wb);
      chk($sformatf("v%0d_rd_count", i), rd_cnt, vecs[i].busy0);
      if (vecs[i].wb) begin
        chk($sformatf("v%0d_wb_addr", i), wb_addr, vecs[i].wba);
        chk($sformatf("v%0d_wb_data", i), wb_blk, vecs[i].wbb);
      end
      if (vecs[i].busy0) chk($sformatf("v%0d_refill_addr", i), rd_addr, vecs[i].a[31:4]);
`ifdef DCACHE_STATS_EN
      if (i == 3) begin
        chk("stats_hits_s123", hit_count, 2);
        chk("stats_misses_s123", miss_count, 2);
      end
`endif
    end

    // Reset during ALLOCATE, then a stray ack.
    resp_en = 1'b0;
    d_mem_r = 1'b1;
    address = 32'h10;
    #1;
    chk("s5_busy_detect", busy, 1);
    k = 0;
    while (!mem_read && k < 8) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("s5_alloc_req", mem_read, 1);
    chk("s5_alloc_addr", mem_address, 28'h1);
    reset = 1'b1;
    d_mem_r = 1'b0;
    #1;
    chk("s5_rst_mem_read", mem_read, 0);
    chk("s5_rst_busy", busy, 0);
    chk("s5_rst_mem_address", mem_address, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    man_ack = 1'b1;
    @(posedge clk);
    #1;
    man_ack = 1'b0;
    chk("s5_ack_mem_read", mem_read, 0);
    chk("s5_ack_mem_write", mem_write, 0);
    chk("s5_ack_busy", busy, 0);
    resp_en = 1'b1;
    access(1'b0, 32'h10, 32'h0, b0, cyc, rdv);
    chk("s5_reload_miss", b0, 1);
    chk("s5_reload_cycles", cyc, 5);
    chk("s5_reload_rd_data", rdv, 32'h11);

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 250; n++) begin
      k = $urandom_range(0, 4);
      w = 1'($urandom_range(0, 1));
      a = (k == 4) ? 32'hFFFF_FF80 : (k << 7);
      a = a | ($urandom_range(0, 7) << 4) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      d = $urandom;
      wdelay = $urandom_range(1, 4);
      rdelay = $urandom_range(1, 4);
      model_predict(w, a, d, e_miss, e_cyc, e_wb, e_wba, e_wbb, e_rd);
      access(w, a, d, b0, cyc, rdv);
      chk("rnd_busy0", b0, e_miss);
      chk("rnd_cycles", cyc, e_cyc);
      if (!w) chk("rnd_rd_data", rdv, e_rd);
      chk("rnd_wb_count", wb_cnt, e_wb);
      chk("rnd_rd_count", rd_cnt, e_miss);
      if (e_wb) begin
        chk("rnd_wb_addr", wb_addr, e_wba);
        chk("rnd_wb_data", wb_blk, e_wbb);
      end
      if (e_miss) chk("rnd_refill_addr", rd_addr, a[31:4]);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
`ifdef DCACHE_STATS_EN
    chk("rnd_hit_count", hit_count, m_hits);
    chk("rnd_miss_count", miss_count, m_misses);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
